// File: rtl/vga_bus_pkg.sv
// Shared constants and types for the VGA fill engine.
//   - Default VGA register window base and register offsets (X, Y, pixel).
//   - Default frame geometry and burst length.
//   - FSM state encoding and a bound-clipping helper.
package vga_bus_pkg;

   localparam logic [7:0]  DefVgaBase  = 8'hB0;
   localparam logic [7:0]  RegXOfs     = 8'd0;
   localparam logic [7:0]  RegYOfs     = 8'd1;
   localparam logic [7:0]  RegPixOfs   = 8'd2;

   localparam int unsigned DefFrameW   = 160;
   localparam int unsigned DefFrameH   = 120;
   localparam int unsigned DefBurstLen = 16;

   // There is no separate NEXT state: the pixel-advance decision is taken on the
   // edge that completes the pixel write, so it costs no bus cycle.
   typedef enum logic [2:0] {
      StIdle,
      StEmpty,
      StReq,
      StWrY,
      StWrX,
      StWrP,
      StYield
   } fill_state_e;

   // Clamp an inclusive upper bound to lim-1.
   function automatic logic [7:0] clip_bound(input logic [7:0] v, input int unsigned lim);
      logic [7:0] max_v;
      max_v = 8'(lim - 1);
      return (v > max_v) ? max_v : v;
   endfunction

endpackage

// File: rtl/vga_fill_addr_gen.sv
// Pixel address generator for the fill engine.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   load_i              : latch bounds and reset counters (accepted START)
//   step_i              : one pixel write has completed; advance raster position
//   x0_i..y1_i          : raw rectangle bounds (upper bounds are clipped here)
//   empty_o             : raw bounds describe an empty rectangle after clipping
//   x_o, y_o            : current pixel position
//   row_end_o           : current pixel is the last one in its row
//   last_o              : current pixel is the last one of the fill
//   burst_end_o         : current pixel completes a burst of BurstLen pixels
module vga_fill_addr_gen
   import vga_bus_pkg::*;
#(
   parameter int unsigned FrameW   = DefFrameW,
   parameter int unsigned FrameH   = DefFrameH,
   parameter int unsigned BurstLen = DefBurstLen
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       load_i,
   input  logic       step_i,
   input  logic [7:0] x0_i,
   input  logic [7:0] y0_i,
   input  logic [7:0] x1_i,
   input  logic [7:0] y1_i,
   output logic       empty_o,
   output logic [7:0] x_o,
   output logic [7:0] y_o,
   output logic       row_end_o,
   output logic       last_o,
   output logic       burst_end_o
);

   localparam logic [7:0] BurstLast = 8'(BurstLen - 1);

   logic [7:0] x1_clip, y1_clip;
   logic [7:0] x0_q, x0_d;
   logic [7:0] x1_q, x1_d;
   logic [7:0] y1_q, y1_d;
   logic [7:0] x_q, x_d;
   logic [7:0] y_q, y_d;
   logic [7:0] burst_q, burst_d;

   assign x1_clip = clip_bound(x1_i, FrameW);
   assign y1_clip = clip_bound(y1_i, FrameH);
   assign empty_o = (x0_i > x1_clip) || (y0_i > y1_clip);

   assign x_o         = x_q;
   assign y_o         = y_q;
   assign row_end_o   = (x_q == x1_q);
   assign last_o      = row_end_o && (y_q == y1_q);
   assign burst_end_o = (burst_q == BurstLast);

   always_comb begin
      x0_d    = x0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      x_d     = x_q;
      y_d     = y_q;
      burst_d = burst_q;
      if (load_i) begin
         x0_d    = x0_i;
         x1_d    = x1_clip;
         y1_d    = y1_clip;
         x_d     = x0_i;
         y_d     = y0_i;
         burst_d = 8'd0;
      end else if (step_i) begin
         if (row_end_o) begin
            x_d = x0_q;
            y_d = y_q + 8'd1;
         end else begin
            x_d = x_q + 8'd1;
         end
         burst_d = burst_end_o ? 8'd0 : burst_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         x0_q    <= 8'd0;
         x1_q    <= 8'd0;
         y1_q    <= 8'd0;
         x_q     <= 8'd0;
         y_q     <= 8'd0;
         burst_q <= 8'd0;
      end else begin
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         x_q     <= x_d;
         y_q     <= y_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: rtl/vga_fill_engine.sv
// Bus initiator that fills a rectangle of the 1-bit frame buffer with one pixel value
// by writing the VGA register window (base+0 = X, base+1 = Y, base+2 = pixel).
//   clk_i, reset_i        : clock, synchronous active-high reset
//   start_i               : 1-cycle pulse, latches bounds and pixel when idle
//   x0_i, x1_i, y0_i, y1_i: inclusive rectangle bounds (upper bounds clipped)
//   pixel_i               : value written to every pixel
//   abort_i               : (only with VGA_FILL_ABORT_EN) stop the fill early
//   busy_o, done_o        : fill in progress / 1-cycle completion pulse
//   bus_req_o, bus_gnt_i  : arbiter handshake
//   bus_addr_io, bus_data_io, bus_we_io : shared bus, driven only while owned
// Optional feature macro: VGA_FILL_ABORT_EN adds the abort_i input.
module vga_fill_engine
   import vga_bus_pkg::*;
#(
   parameter logic [7:0]  VgaBase  = DefVgaBase,
   parameter int unsigned FrameW   = DefFrameW,
   parameter int unsigned FrameH   = DefFrameH,
   parameter int unsigned BurstLen = DefBurstLen
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] x0_i,
   input  logic [7:0] x1_i,
   input  logic [7:0] y0_i,
   input  logic [7:0] y1_i,
   input  logic       pixel_i,
`ifdef VGA_FILL_ABORT_EN
   input  logic       abort_i,
`endif
   output logic       busy_o,
   output logic       done_o,
   output logic       bus_req_o,
   input  logic       bus_gnt_i,
   inout  wire  [7:0] bus_addr_io,
   inout  wire  [7:0] bus_data_io,
   inout  wire        bus_we_io
);

   fill_state_e state_q;
   logic        busy_q, done_q, bus_req_q, pixel_q;
   logic        abort;
   logic        load, step, empty, row_end, last, burst_end;
   logic [7:0]  x, y;
   logic        wr_state, own;
   logic [7:0]  addr_mux, data_mux;

`ifdef VGA_FILL_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   assign load = (state_q == StIdle) && start_i && !abort;
   // A pixel counts only when its WR_P cycle completes under grant.
   assign step = (state_q == StWrP) && bus_gnt_i;

   vga_fill_addr_gen #(
      .FrameW   (FrameW),
      .FrameH   (FrameH),
      .BurstLen (BurstLen)
   ) u_addr_gen (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (load),
      .step_i      (step),
      .x0_i        (x0_i),
      .y0_i        (y0_i),
      .x1_i        (x1_i),
      .y1_i        (y1_i),
      .empty_o     (empty),
      .x_o         (x),
      .y_o         (y),
      .row_end_o   (row_end),
      .last_o      (last),
      .burst_end_o (burst_end)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bus_req_q <= 1'b0;
         pixel_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort && (state_q != StIdle)) begin
            // Any write on the bus this cycle completes at this edge.
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            bus_req_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (load) begin
                     pixel_q <= pixel_i;
                     busy_q  <= 1'b1;
                     if (empty) begin
                        state_q <= StEmpty;
                     end else begin
                        state_q   <= StReq;
                        bus_req_q <= 1'b1;
                     end
                  end
               end
               StEmpty: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
               StReq: if (bus_gnt_i) state_q <= StWrY;
               StWrY: if (bus_gnt_i) state_q <= StWrX;
               StWrX: if (bus_gnt_i) state_q <= StWrP;
               StWrP: begin
                  if (bus_gnt_i) begin
                     if (last) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        bus_req_q <= 1'b0;
                     end else if (burst_end) begin
                        state_q   <= StYield;
                        bus_req_q <= 1'b0;
                     end else if (row_end) begin
                        state_q <= StWrY;
                     end else begin
                        state_q <= StWrX;
                     end
                  end
               end
               StYield: begin
                  // Regrant always re-enters via WR_Y: another master may have moved Y.
                  state_q   <= StReq;
                  bus_req_q <= 1'b1;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      wr_state = 1'b0;
      addr_mux = 8'd0;
      data_mux = 8'd0;
      unique case (state_q)
         StWrY: begin
            wr_state = 1'b1;
            addr_mux = VgaBase + RegYOfs;
            data_mux = y;
         end
         StWrX: begin
            wr_state = 1'b1;
            addr_mux = VgaBase + RegXOfs;
            data_mux = x;
         end
         StWrP: begin
            wr_state = 1'b1;
            addr_mux = VgaBase + RegPixOfs;
            data_mux = {7'd0, pixel_q};
         end
         default: ;
      endcase
   end

   // Grant enters combinationally so a lost grant releases the pins in the same cycle.
   assign own = wr_state && bus_req_q && bus_gnt_i;

   assign bus_addr_io = own ? addr_mux : 8'hzz;
   assign bus_data_io = own ? data_mux : 8'hzz;
   assign bus_we_io   = own ? 1'b1 : 1'bz;

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign bus_req_o = bus_req_q;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Self-checking bench for vga_fill_engine: a frame-buffer model is updated from observed
// bus writes and compared with a rectangle fill computed directly from the bounds.
module tb_vga_fill_engine;

   localparam int         W   = 160;
   localparam int         H   = 120;
   localparam int         BL  = 16;
   localparam int         Lim = 60000;
   localparam logic [7:0] AX  = 8'hB0;
   localparam logic [7:0] AY  = 8'hB1;
   localparam logic [7:0] AP  = 8'hB2;

   logic       clk = 1'b0;
   logic       reset, start, pixel, gnt;
   logic [7:0] x0, y0, x1, y1;
   logic       busy, done, req;
   wire  [7:0] bus_addr, bus_data;
   wire        bus_we;
`ifdef VGA_FILL_ABORT_EN
   logic       abort = 1'b0;
`endif

   vga_fill_engine #(
      .BurstLen (BL)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .x0_i        (x0),
      .x1_i        (x1),
      .y0_i        (y0),
      .y1_i        (y1),
      .pixel_i     (pixel),
`ifdef VGA_FILL_ABORT_EN
      .abort_i     (abort),
`endif
      .busy_o      (busy),
      .done_o      (done),
      .bus_req_o   (req),
      .bus_gnt_i   (gnt),
      .bus_addr_io (bus_addr),
      .bus_data_io (bus_data),
      .bus_we_io   (bus_we)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit rand_gnt = 1'b0;

   bit fb     [W][H];
   bit exp_fb [W][H];
   int rx = 0, ry = 0;
   int pix_wr = 0, y_wr = 0, done_cnt = 0, req_cyc = 0, own_viol = 0;
   logic [15:0] trace [$];
   int yield_at [$];

   // Bus monitor: a write seen mid-cycle completes at the next edge (grant only moves after it).
   always @(negedge clk) begin
      if (bus_we === 1'b1) begin
         if (gnt !== 1'b1 || req !== 1'b1) own_viol <= own_viol + 1;
         trace.push_back({bus_addr, bus_data});
         if (bus_addr == AX) rx <= int'(bus_data);
         else if (bus_addr == AY) begin
            ry   <= int'(bus_data);
            y_wr <= y_wr + 1;
         end else if (bus_addr == AP) begin
            pix_wr <= pix_wr + 1;
            if (rx < W && ry < H) fb[rx][ry] <= bus_data[0];
         end
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (req === 1'b1) req_cyc <= req_cyc + 1;
      if (busy === 1'b1 && req !== 1'b1 && pix_wr > 0) yield_at.push_back(pix_wr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rand_gnt) gnt = ($urandom_range(0, 3) != 0);
   endtask

   function automatic int fb_mismatches();
      int m = 0;
      for (int i = 0; i < W; i++)
         for (int j = 0; j < H; j++)
            if (fb[i][j] != exp_fb[i][j]) m++;
      return m;
   endfunction

   task automatic clear_counts();
      pix_wr = 0; y_wr = 0; done_cnt = 0; req_cyc = 0;
      trace.delete();
      yield_at.delete();
   endtask

   task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                           input bit p, input bit rg, input bit ign, input string tag);
      int cx1, cy1, area, exp_y, exp_yl, t, bad;
      cx1 = (ax1 > W - 1) ? W - 1 : ax1;
      cy1 = (ay1 > H - 1) ? H - 1 : ay1;
      area = 0;
      exp_y = 0;
      // Raster order; a Y write precedes the first pixel, each new row, and each regrant.
      if (ax0 <= cx1 && ay0 <= cy1) begin
         for (int yy = ay0; yy <= cy1; yy++) begin
            for (int xx = ax0; xx <= cx1; xx++) begin
               area++;
               if (area == 1 || xx == ax0 || (area - 1) % BL == 0) exp_y++;
               exp_fb[xx][yy] = p;
            end
         end
      end
      exp_yl = (area > 0) ? (area - 1) / BL : 0;
      clear_counts();
      x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1); pixel = p;
      rand_gnt = rg;
      start = 1'b1;
      cyc();
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      t = 0;
      while (done !== 1'b1 && t < Lim) begin
         start = ign && (t == 10);
         if (start) begin
            x0 = 8'd0; y0 = 8'd0; x1 = 8'd159; y1 = 8'd119; pixel = ~p;
         end
         cyc();
         start = 1'b0;
         t++;
      end
      check({tag, "_timeout"}, 32'(t < Lim), 32'd1);
      if (area == 0) check({tag, "_empty_lat"}, 32'(t), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      rand_gnt = 1'b0;
      gnt = 1'b1;
      repeat (3) cyc();
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_req_after"}, 32'(req), 32'd0);
      check({tag, "_pix_writes"}, 32'(pix_wr), 32'(area));
      check({tag, "_y_writes"}, 32'(y_wr), 32'(exp_y));
      check({tag, "_yields"}, 32'(yield_at.size()), 32'(exp_yl));
      bad = 0;
      for (int i = 0; i < yield_at.size(); i++) if (yield_at[i] != (i + 1) * BL) bad++;
      check({tag, "_yield_pos"}, 32'(bad), 32'd0);
      check({tag, "_ownership"}, 32'(own_viol), 32'd0);
      check({tag, "_fb"}, 32'(fb_mismatches()), 32'd0);
      if (area == 0) check({tag, "_no_req"}, 32'(req_cyc), 32'd0);
   endtask

   initial begin
      int bad, t, idx;
      reset = 1'b1; start = 1'b0; gnt = 1'b1; pixel = 1'b0;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
      repeat (3) cyc();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_req", 32'(req), 32'd0);
      check("rst_we_z", 32'(bus_we === 1'b1), 32'd0);
      reset = 1'b0;
      cyc();

      // Reset in the middle of a fill.
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd159; y1 = 8'd119; pixel = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (100) cyc();
      check("midrst_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      cyc();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_req", 32'(req), 32'd0);
      check("midrst_we_z", 32'(bus_we === 1'b1), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      cyc();

      run_fill(0, 0, 159, 119, 1'b0, 1'b0, 1'b0, "clear");

      run_fill(5, 7, 5, 7, 1'b1, 1'b0, 1'b0, "single");
      check("single_len", 32'(trace.size()), 32'd3);
      check("single_w0", 32'(trace[0]), 32'h0000_B107);
      check("single_w1", 32'(trace[1]), 32'h0000_B005);
      check("single_w2", 32'(trace[2]), 32'h0000_B201);

      run_fill(150, 110, 200, 200, 1'b1, 1'b0, 1'b0, "clip");
      idx = trace.size() - 2;
      check("clip_last_x", 32'(trace[idx]), 32'h0000_B09F);

      run_fill(10, 0, 9, 5, 1'b1, 1'b0, 1'b0, "empty");

      // Arbitration: long initial wait, then grant lost in the middle of WR_X.
      clear_counts();
      exp_fb[20][30] = 1'b1;
      gnt = 1'b0;
      x0 = 8'd20; y0 = 8'd30; x1 = 8'd20; y1 = 8'd30; pixel = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy !== 1'b1 || req !== 1'b1 || bus_we === 1'b1) bad++;
         cyc();
      end
      check("arb_wait", 32'(bad), 32'd0);
      gnt = 1'b1;
      cyc();
      check("arb_y_we", 32'(bus_we === 1'b1), 32'd1);
      check("arb_y_addr", 32'(bus_addr), 32'(AY));
      cyc();
      check("arb_x_addr", 32'(bus_addr), 32'(AX));
      gnt = 1'b0;
      #1;
      check("arb_x_z", 32'(bus_we === 1'b1), 32'd0);
      check("arb_x_req", 32'(req), 32'd1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (bus_we === 1'b1 || req !== 1'b1 || busy !== 1'b1) bad++;
      end
      check("arb_hold", 32'(bad), 32'd0);
      gnt = 1'b1;
      #1;
      check("arb_retry_we", 32'(bus_we === 1'b1), 32'd1);
      check("arb_retry_addr", 32'(bus_addr), 32'(AX));
      check("arb_retry_data", 32'(bus_data), 32'd20);
      t = 0;
      while (done !== 1'b1 && t < 50) begin
         cyc();
         t++;
      end
      check("arb_timeout", 32'(t < 50), 32'd1);
      repeat (2) cyc();
      check("arb_done_cnt", 32'(done_cnt), 32'd1);
      check("arb_len", 32'(trace.size()), 32'd3);
      check("arb_w0", 32'(trace[0]), 32'h0000_B11E);
      check("arb_w1", 32'(trace[1]), 32'h0000_B014);
      check("arb_w2", 32'(trace[2]), 32'h0000_B201);
      check("arb_fb", 32'(fb_mismatches()), 32'd0);

      run_fill(40, 50, 42, 65, 1'b1, 1'b0, 1'b0, "yield");

      for (int r = 0; r < 4; r++) begin
         int a, b, c, d;
         a = int'($urandom_range(0, 165));
         b = int'($urandom_range(0, 125));
         c = a + int'($urandom_range(0, 30)) - 2;
         d = b + int'($urandom_range(0, 30)) - 2;
         if (c < 0) c = 0;
         if (d < 0) d = 0;
         run_fill(a, b, c, d, 1'($urandom_range(0, 1)), 1'b1, (r == 0), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
